vproc_mem_responder: RTL

- Bus responder (target) at the far end of the VProc virtual-processor bus; services single and burst reads/writes from one VProc node.
- Contains a word-addressed RAM, a configurable wait-state generator, and single-cycle WRAck/RDAck pulses matching the VProc sampling rules.
- Lives in test harnesses alongside VProc as the default memory/register target.

---
 rtl/vproc_mem_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vproc_mem_responder.sv
// VProc bus responder: word-addressed RAM target with per-direction wait states and one-cycle acks.
// Optional byte-lane write enables are compiled in with VPROC_RESP_BE_EN.
module vproc_mem_responder #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RD_WAIT    = 1,
   parameter int          WR_WAIT    = 0,
   parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic        Clk,
   input  logic        nReset,
   input  logic [31:0] Addr,
`ifdef VPROC_RESP_BE_EN
   input  logic [3:0]  BE,
`endif
   input  logic        WE,
   input  logic        RD,
   input  logic [31:0] DataIn,
   input  logic [11:0] Burst,
   input  logic        BurstFirst,
   input  logic        BurstLast,
   output logic [31:0] DataOut,
   output logic        WRAck,
   output logic        RDAck,
   output logic        Err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   localparam logic [7:0] RD_WAIT_C = 8'(RD_WAIT);
   localparam logic [7:0] WR_WAIT_C = 8'(WR_WAIT);
   localparam int         DEPTH     = 1 << ADDR_WIDTH;

   logic [1:0]  state_reg;
   logic [7:0]  wait_cnt_reg;
   logic        op_wr_reg;
   logic        op_both_reg;
   logic [31:0] mem [0:DEPTH-1];

   logic                  req;
   logic                  still_req;
   logic                  first_beat;
   logic [7:0]            req_wait;
   logic                  go_ack;
   logic                  acc_wr;
   logic                  acc_both;
   logic                  in_range;
   logic                  ram_we;
   logic [3:0]            wr_lanes;
   logic [ADDR_WIDTH-1:0] ram_idx;
   logic                  unused_inputs;

   assign unused_inputs = BurstLast;

   assign req        = WE | RD;
   assign still_req  = op_wr_reg ? WE : RD;
   assign first_beat = (Burst == 12'd0) | BurstFirst;
   // A simultaneous RD+WE is serviced as a write, so it takes the write wait count.
   assign req_wait   = first_beat ? (WE ? WR_WAIT_C : RD_WAIT_C) : 8'd0;
   assign in_range   = (Addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
   assign ram_idx    = Addr[ADDR_WIDTH-1:0];

`ifdef VPROC_RESP_BE_EN
   assign wr_lanes = BE;
`else
   assign wr_lanes = 4'hF;
`endif

   always_comb begin
      go_ack   = 1'b0;
      acc_wr   = op_wr_reg;
      acc_both = op_both_reg;
      case (state_reg)
         ST_IDLE: begin
            acc_wr   = WE;
            acc_both = WE & RD;
            go_ack   = req && (req_wait == 8'd0);
         end
         ST_WAIT: go_ack = still_req && (wait_cnt_reg == 8'd1);
         default: go_ack = 1'b0;
      endcase
   end

   // Gated by reset so an access landing on a reset edge never reaches the RAM.
   assign ram_we = nReset & go_ack & acc_wr & in_range;

   always_ff @(posedge Clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_lanes[i]) begin
               mem[ram_idx][i*8 +: 8] <= DataIn[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!nReset) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= 8'd0;
         op_wr_reg    <= 1'b0;
         op_both_reg  <= 1'b0;
         DataOut      <= 32'd0;
         WRAck        <= 1'b0;
         RDAck        <= 1'b0;
         Err          <= 1'b0;
      end else begin
         WRAck <= 1'b0;
         RDAck <= 1'b0;
         Err   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (req) begin
                  op_wr_reg   <= WE;
                  op_both_reg <= WE & RD;
                  if (req_wait == 8'd0) begin
                     state_reg <= ST_ACK;
                  end else begin
                     wait_cnt_reg <= req_wait;
                     state_reg    <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!still_req) begin
                  wait_cnt_reg <= 8'd0;
                  state_reg    <= ST_IDLE;
               end else if (wait_cnt_reg == 8'd1) begin
                  wait_cnt_reg <= 8'd0;
                  state_reg    <= ST_ACK;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 8'd1;
               end
            end
            // The request is still visible during the ack cycle; it is deliberately not re-serviced.
            ST_ACK:  state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
         if (go_ack) begin
            WRAck <= acc_wr;
            RDAck <= ~acc_wr;
            Err   <= ~in_range | acc_both;
            if (!acc_wr) begin
               DataOut <= in_range ? mem[ram_idx] : ERR_DATA;
            end
         end
      end
   end

endmodule
